// File: rtl/cmd_resp_ctrl_if.sv
// Reply byte stream handshake between the command controller and the UART send module.
interface cmd_resp_ctrl_if;
    logic       send_valid;
    logic [7:0] send_data;
    logic       send_ready;

    modport master (output send_valid, output send_data, input send_ready);
    modport slave  (input send_valid, input send_data, output send_ready);
endinterface

// File: rtl/cmd_resp_ctrl.sv
// Command controller: tracks run enable and streams a fixed ASCII reply per command.
// Optional macro CMD_DROP_CNT_EN adds a saturating dropped-command counter port.
module cmd_resp_ctrl #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned GAP_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_is_start,
    input  logic            i_is_stop,
    input  logic            i_other,
    cmd_resp_ctrl_if.master send_if,
    output logic            o_run_en,
    output logic            o_busy,
    output logic            o_resp_done
`ifdef CMD_DROP_CNT_EN
    ,
    output logic [7:0]      o_drop_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_STOP  = 2'd1;
    localparam logic [1:0] SEL_OTHER = 2'd2;

    function automatic logic [7:0] rom_byte(input logic [1:0] sel, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h0A;
        if (sel == SEL_START) begin
            case (idx)
                3'd0:    b = 8'h4F;
                3'd1:    b = 8'h4E;
                3'd2:    b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end else if (sel == SEL_STOP) begin
            case (idx)
                3'd0:    b = 8'h4F;
                3'd1:    b = 8'h46;
                3'd2:    b = 8'h46;
                3'd3:    b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end else begin
            case (idx)
                3'd0:    b = 8'h45;
                3'd1:    b = 8'h52;
                3'd2:    b = 8'h52;
                3'd3:    b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end
        return b;
    endfunction

    function automatic logic [2:0] rom_last(input logic [1:0] sel);
        return (sel == SEL_START) ? 3'd3 : 3'd4;
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       r_sel;
    logic [2:0]       r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_pend_vld;
    logic [1:0]       r_pend_sel;
    logic             r_run_en;
    logic [7:0]       r_send_data;

    logic             w_cmd_vld;
    logic [1:0]       w_cmd_sel;
    logic [1:0]       w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [2:0]       w_idx_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_pend_vld_nxt;
    logic [1:0]       w_pend_sel_nxt;

    assign w_cmd_vld = i_is_start | i_is_stop | i_other;
    assign w_cmd_sel = i_is_start ? SEL_START : (i_is_stop ? SEL_STOP : SEL_OTHER);

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_idx_nxt      = r_idx;
        w_gap_nxt      = r_gap_cnt;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_sel_nxt = r_pend_sel;
        case (r_state)
            ST_IDLE: begin
                // A queued command has priority; a fresh one in the same cycle refills the slot.
                if (r_pend_vld) begin
                    w_state_nxt    = ST_SEND;
                    w_sel_nxt      = r_pend_sel;
                    w_idx_nxt      = 3'd0;
                    w_pend_vld_nxt = w_cmd_vld;
                    w_pend_sel_nxt = w_cmd_sel;
                end else if (w_cmd_vld) begin
                    w_state_nxt = ST_SEND;
                    w_sel_nxt   = w_cmd_sel;
                    w_idx_nxt   = 3'd0;
                end
            end
            ST_SEND: begin
                if (send_if.send_ready) begin
                    if (r_idx == rom_last(r_sel)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = ST_GAP;
                            w_gap_nxt   = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && w_cmd_vld && !r_pend_vld) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_sel_nxt = w_cmd_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= SEL_START;
            r_idx       <= 3'd0;
            r_gap_cnt   <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_sel  <= SEL_START;
            r_run_en    <= 1'b0;
            r_send_data <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_idx      <= w_idx_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_sel <= w_pend_sel_nxt;
            // Data is loaded for the coming SEND cycle and otherwise holds the last byte.
            if (w_state_nxt == ST_SEND) begin
                r_send_data <= rom_byte(w_sel_nxt, w_idx_nxt);
            end
            if (i_is_start) begin
                r_run_en <= 1'b1;
            end else if (i_is_stop) begin
                r_run_en <= 1'b0;
            end
        end
    end

`ifdef CMD_DROP_CNT_EN
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    assign w_drop = (r_state != ST_IDLE) && w_cmd_vld && r_pend_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign send_if.send_valid = (r_state == ST_SEND);
    assign send_if.send_data  = r_send_data;
    assign o_run_en           = r_run_en;
    assign o_busy             = (r_state != ST_IDLE);
    assign o_resp_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_cmd_resp_ctrl.sv
// Bench for cmd_resp_ctrl: directed scenarios plus random traffic against a reply-queue model.
module tb_cmd_resp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic is_start, is_stop, other;
    logic run_en, busy, resp_done;
    logic g_start, g_run, g_busy, g_done;
`ifdef CMD_DROP_CNT_EN
    logic [7:0] drop_cnt, g_drop;
`endif

    cmd_resp_ctrl_if sif();
    cmd_resp_ctrl_if gif();

    cmd_resp_ctrl #(.GAP_CYCLES(0), .GAP_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_is_start  (is_start),
        .i_is_stop   (is_stop),
        .i_other     (other),
        .send_if     (sif),
        .o_run_en    (run_en),
        .o_busy      (busy),
        .o_resp_done (resp_done)
`ifdef CMD_DROP_CNT_EN
        ,
        .o_drop_cnt  (drop_cnt)
`endif
    );

    cmd_resp_ctrl #(.GAP_CYCLES(3), .GAP_W(8)) dut_g (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_is_start  (g_start),
        .i_is_stop   (1'b0),
        .i_other     (1'b0),
        .send_if     (gif),
        .o_run_en    (g_run),
        .o_busy      (g_busy),
        .o_resp_done (g_done)
`ifdef CMD_DROP_CNT_EN
        ,
        .o_drop_cnt  (g_drop)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the active reply as a byte queue plus a one-entry waiting slot.
    bit         m_active, m_done, m_pend, m_run;
    int         m_pend_sel, m_drop;
    logic [7:0] m_bytes[$];
    logic [7:0] m_last;
    logic [7:0] got[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_reply(input int s);
        if (s == 0)      m_bytes = '{8'h4F, 8'h4E, 8'h0D, 8'h0A};
        else if (s == 1) m_bytes = '{8'h4F, 8'h46, 8'h46, 8'h0D, 8'h0A};
        else             m_bytes = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
        m_active = 1'b1;
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_run = 1'b0;
        m_pend_sel = 0; m_drop = 0; m_last = 8'h00;
        m_bytes.delete();
    endtask

    task automatic tick();
        bit cv, ev;
        int cs;
        @(negedge clk);
        ev = m_active && (m_bytes.size() > 0);
        chk("send_valid", {7'd0, sif.send_valid}, {7'd0, ev});
        chk("busy", {7'd0, busy}, {7'd0, m_active || m_done});
        chk("resp_done", {7'd0, resp_done}, {7'd0, m_done});
        chk("run_en", {7'd0, run_en}, {7'd0, m_run});
        chk("send_data", sif.send_data, ev ? m_bytes[0] : m_last);
`ifdef CMD_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, 8'(m_drop));
`endif
        if (rst_n) begin
            cv = is_start || is_stop || other;
            cs = is_start ? 0 : (is_stop ? 1 : 2);
            if (sif.send_valid && sif.send_ready) got.push_back(sif.send_data);
            if (m_active || m_done) begin
                if (m_done) begin
                    m_done = 1'b0;
                end else if (ev && sif.send_ready) begin
                    m_last = m_bytes.pop_front();
                    if (m_bytes.size() == 0) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
                if (cv) begin
                    if (!m_pend) begin
                        m_pend = 1'b1;
                        m_pend_sel = cs;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
            end else if (m_pend) begin
                load_reply(m_pend_sel);
                m_pend = cv;
                m_pend_sel = cs;
            end else if (cv) begin
                load_reply(cs);
            end
            if (is_start) m_run = 1'b1;
            else if (is_stop) m_run = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] e[$]);
        chk({tag, "_len"}, 8'(got.size()), 8'(e.size()));
        for (int i = 0; i < e.size() && i < got.size(); i++) chk(tag, got[i], e[i]);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] gb[$];
    int         gc[$];
    int         ndone;

    initial begin
        rst_n = 1'b0;
        is_start = 1'b0; is_stop = 1'b0; other = 1'b0; g_start = 1'b0;
        sif.send_ready = 1'b0;
        gif.send_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", {7'd0, sif.send_valid}, 8'd0);
        chk("rst_data", sif.send_data, 8'h00);
        chk("rst_run", {7'd0, run_en}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, resp_done}, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Start with ready held high: four back-to-back bytes.
        sif.send_ready = 1'b1;
        got.delete();
        is_start = 1'b1; tick(); is_start = 1'b0;
        repeat (8) tick();
        exp_q = '{8'h4F, 8'h4E, 8'h0D, 8'h0A};
        chk_stream("on_stream", exp_q);
        chk("on_run", {7'd0, run_en}, 8'd1);
        chk("on_idle", {7'd0, busy}, 8'd0);

        // Stop with toggling ready.
        got.delete();
        is_stop = 1'b1; tick(); is_stop = 1'b0;
        for (int i = 0; i < 14; i++) begin
            sif.send_ready = (i % 2 == 0);
            tick();
        end
        exp_q = '{8'h4F, 8'h46, 8'h46, 8'h0D, 8'h0A};
        chk_stream("off_stream", exp_q);
        chk("off_run", {7'd0, run_en}, 8'd0);

        // other queued, stop dropped during the ON reply.
        sif.send_ready = 1'b1;
        got.delete();
        is_start = 1'b1; tick(); is_start = 1'b0;
        tick();
        other = 1'b1; tick(); other = 1'b0;
        is_stop = 1'b1; tick(); is_stop = 1'b0;
        repeat (16) tick();
        exp_q = '{8'h4F, 8'h4E, 8'h0D, 8'h0A, 8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
        chk_stream("queue_stream", exp_q);
        chk("queue_run", {7'd0, run_en}, 8'd0);
`ifdef CMD_DROP_CNT_EN
        chk("queue_drop", drop_cnt, 8'd1);
`endif

        // Simultaneous start and other resolve to start only.
        got.delete();
        is_start = 1'b1; other = 1'b1; tick(); is_start = 1'b0; other = 1'b0;
        repeat (10) tick();
        exp_q = '{8'h4F, 8'h4E, 8'h0D, 8'h0A};
        chk_stream("prio_stream", exp_q);
        chk("prio_run", {7'd0, run_en}, 8'd1);

        // Gap instance: three idle cycles between accepted bytes.
        gif.send_ready = 1'b1;
        g_start = 1'b1; @(posedge clk); #1; g_start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (gif.send_valid) begin
                gb.push_back(gif.send_data);
                gc.push_back(c);
            end
            if (g_done) ndone++;
            @(posedge clk); #1;
        end
        chk("gap_count", 8'(gb.size()), 8'd4);
        exp_q = '{8'h4F, 8'h4E, 8'h0D, 8'h0A};
        for (int i = 0; i < 4 && i < gb.size(); i++) chk("gap_byte", gb[i], exp_q[i]);
        for (int i = 0; i + 1 < gc.size(); i++) chk("gap_spacing", 8'(gc[i+1] - gc[i]), 8'd4);
        chk("gap_done", 8'(ndone), 8'd1);
        chk("gap_run", {7'd0, g_run}, 8'd1);

        // Reset at idx 2 of ERR with START waiting.
        sif.send_ready = 1'b0;
        other = 1'b1; tick(); other = 1'b0;
        tick();
        is_start = 1'b1; tick(); is_start = 1'b0;
        sif.send_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, sif.send_valid}, 8'd0);
        chk("mid_rst_data", sif.send_data, 8'h00);
        chk("mid_rst_run", {7'd0, run_en}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_done", {7'd0, resp_done}, 8'd0);
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        got.delete();
        repeat (10) tick();
        chk("post_rst_bytes", 8'(got.size()), 8'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            sif.send_ready = ($urandom_range(0, 3) != 0);
            is_start = ($urandom_range(0, 15) == 0);
            is_stop  = ($urandom_range(0, 15) == 0);
            other    = ($urandom_range(0, 15) == 0);
            tick();
        end
        is_start = 1'b0; is_stop = 1'b0; other = 1'b0;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_resp_ctrl.md
Name: cmd_resp_ctrl

Overview:
- Command controller downstream of the UART command recogniser.
- Consumes the one-cycle `is_start` / `is_stop` / `other` pulses and maintains a run-enable flag for the application datapath.
- Sequences a fixed ASCII reply string, byte by byte, into the UART send module through a valid/ready handshake.
- Holds a one-deep pending slot so that a command arriving mid-reply is not lost.

Parameters:
- GAP_CYCLES, 0: idle cycles inserted after each accepted byte, with send_valid low during the gap.
- GAP_W, 8: width of the gap counter. GAP_CYCLES must be < 2^GAP_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- is_start  in  1  one-cycle pulse: "start\r" recognised.
- is_stop  in  1  one-cycle pulse: "stop\r" recognised.
- other  in  1  one-cycle pulse: unrecognised line.
- send_ready  in  1  send module accepts send_data this cycle.
- send_valid  out  1  byte on send_data is valid.
- send_data  out  8  reply byte.
- run_en  out  1  application run enable.
- busy  out  1  high in any state other than IDLE.
- resp_done  out  1  one-cycle pulse after the last byte of a reply is accepted.
- drop_cnt  out  8  dropped-command count; present only with CMD_DROP_CNT_EN.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, idx=0, gap counter=0, pending empty.
  - run_en=0, send_valid=0, send_data=8'h00, resp_done=0, drop_cnt=0.
- Command decode: cmd = start if is_start, else stop if is_stop, else other if other. Multiple pulses in one cycle resolve with start > stop > other.
- Reply ROM (2-bit select):
  - START: "ON\r\n" = 4F 4E 0D 0A, len 4.
  - STOP: "OFF\r\n" = 4F 46 46 0D 0A, len 5.
  - OTHER: "ERR\r\n" = 45 52 52 0D 0A, len 5.
- run_en:
  - Set to 1 the cycle after an is_start pulse; cleared to 0 the cycle after an is_stop pulse.
  - `other` leaves it unchanged.
  - It updates on every decoded command, including queued and dropped ones.
- Command intake:
  - In IDLE with pending empty: a command loads sel and idx=0 and moves to SEND on the next edge. First send_valid=1 is 1 cycle after the pulse.
  - In IDLE with pending full: the pending command is started and the slot is cleared. A simultaneous new command goes into the slot.
  - While busy with pending empty: the command is stored in the pending slot.
  - While busy with pending full: the new command is dropped; drop_cnt increments and saturates at 255.
- FSM:
  - IDLE -> SEND on a command or pending.
  - SEND:
    - Hold send_valid=1 and send_data=ROM[sel][idx] stable until send_ready=1.
    - On accept, if idx==len-1 go to DONE; else idx+1, then GAP (GAP_CYCLES>0) or stay in SEND (GAP_CYCLES=0).
    - With GAP_CYCLES=0, back-to-back bytes are one per cycle while send_ready stays high.
  - GAP: send_valid=0. Count GAP_CYCLES cycles, then go to SEND.
  - DONE: resp_done=1 for exactly one cycle, busy still 1, send_valid=0; next state IDLE.
  - The pending command starts from IDLE, so there is a minimum 2-cycle gap between replies.
- send_ready while send_valid=0 is ignored.
- send_data keeps its last value when send_valid=0.
- No byte is skipped or repeated under any send_ready pattern.
- Reset mid-reply aborts immediately: the pending command is discarded and no partial completion is signalled.

Optional Feature:
- CMD_DROP_CNT_EN defined: drop_cnt port and 8-bit saturating counter exist, incrementing per dropped command.
- Undefined: no drop_cnt port and no counter; dropped commands are discarded silently; all other behaviour is identical.

Test Plan:
- Reset then is_start pulse, send_ready=1, GAP_CYCLES=0 -> run_en=1 next cycle; send_data 4F,4E,0D,0A on 4 consecutive cycles; resp_done pulse 1 cycle later; busy back to 0.
- is_stop pulse with send_ready toggling 1,0,1,0 -> bytes 4F 46 46 0D 0A each held until accepted, each accepted once; run_en=0.
- other during the "ON" reply, then is_stop during the same reply -> other queued, is_stop dropped (drop_cnt=1), run_en=0; stream shows ON reply then ERR reply, no OFF.
- GAP_CYCLES=3, is_start -> send_valid low exactly 3 cycles between accepted bytes; total 4 bytes.
- rst=0 while idx=2 of ERR with pending=START -> outputs at reset values the same cycle; after release no bytes are sent until a new pulse.
- is_start and other asserted in the same cycle -> treated as start: "ON\r\n" sent, nothing queued.
